// File: rtl/uart_fifo_pkg.sv
// Shared constants and sizing helper for the UART byte FIFO family.
package uart_fifo_pkg;

    localparam int UART_FIFO_DEPTH_DEF = 16;
    localparam int UART_DATA_W         = 8;

    function automatic int addr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/uart_fifo_ctl_if.sv
// Push/pop/status bundle between a UART engine or host port and the FIFO.
interface uart_fifo_ctl_if
    import uart_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_W,
    parameter int DEPTH      = UART_FIFO_DEPTH_DEF
);

    logic                       wr_en;
    logic [DATA_WIDTH-1:0]      din;
    logic                       rd_en;
    logic                       err_clr;
    logic [DATA_WIDTH-1:0]      dout;
    logic                       dout_valid;
    logic                       full;
    logic                       empty;
    logic                       almost_full;
    logic                       almost_empty;
    logic [addr_w(DEPTH):0]     level;
    logic                       overflow;
    logic                       underflow;

    modport master (
        output wr_en, din, rd_en, err_clr,
        input  dout, dout_valid, full, empty, almost_full, almost_empty,
               level, overflow, underflow
    );

    modport slave (
        input  wr_en, din, rd_en, err_clr,
        output dout, dout_valid, full, empty, almost_full, almost_empty,
               level, overflow, underflow
    );

endinterface

// File: rtl/uart_fifo_ram.sv
// Simple dual-port register array: synchronous write, combinational read.
module uart_fifo_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AW         = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_fifo_ctl.sv
// Single-clock UART FIFO controller: pointers, level, thresholds, sticky errors.
// Define UART_FIFO_FWFT_EN for first-word-fall-through reads; default is registered read.
module uart_fifo_ctl
    import uart_fifo_pkg::*;
#(
    parameter int DATA_WIDTH    = UART_DATA_W,
    parameter int DEPTH         = UART_FIFO_DEPTH_DEF,
    parameter int AFULL_THRESH  = DEPTH - 2,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    uart_fifo_ctl_if.slave  bus
);

    localparam int AW = addr_w(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] DEPTH_L  = LW'(DEPTH);
    localparam logic [LW-1:0] AFULL_L  = LW'(AFULL_THRESH);
    localparam logic [LW-1:0] AEMPTY_L = LW'(AEMPTY_THRESH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_fifo_ctl: DEPTH must be a power of two >= 2");
    end
    if (DATA_WIDTH < 1) begin : g_bad_width
        $error("uart_fifo_ctl: DATA_WIDTH must be >= 1");
    end
    if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH ||
        AEMPTY_THRESH < 0 || AEMPTY_THRESH > DEPTH - 1) begin : g_bad_thresh
        $error("uart_fifo_ctl: threshold out of range");
    end

    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         level_q, level_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  full, empty, push_ok, pop_ok;

    assign full    = (level_q == DEPTH_L);
    assign empty   = (level_q == '0);
    assign push_ok = bus.wr_en & ~full;
    assign pop_ok  = bus.rd_en & ~empty;

    uart_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (AW)
    ) u_ram (
        .clk   (clk),
        .we    (push_ok),
        .waddr (wr_ptr_q),
        .wdata (bus.din),
        .raddr (rd_ptr_q),
        .rdata (rdata)
    );

    // Errors are judged on pre-edge state; a fresh error beats err_clr.
    always_comb begin
        wr_ptr_d    = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d    = pop_ok  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d     = level_q;
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        overflow_d  = (bus.wr_en & full)  | (overflow_q  & ~bus.err_clr);
        underflow_d = (bus.rd_en & empty) | (underflow_q & ~bus.err_clr);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

`ifdef UART_FIFO_FWFT_EN
    // Head word is presented directly; gated so an empty FIFO shows zero.
    assign bus.dout       = empty ? '0 : rdata;
    assign bus.dout_valid = ~empty;
`else
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  dout_valid_q, dout_valid_d;

    always_comb begin
        dout_d       = pop_ok ? rdata : dout_q;
        dout_valid_d = pop_ok;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
`endif

    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (level_q >= AFULL_L);
    assign bus.almost_empty = (level_q <= AEMPTY_L);
    assign bus.level        = level_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_uart_fifo_ctl.sv
// Directed bench for uart_fifo_ctl (DEPTH=16, AFULL=14, AEMPTY=2).
module tb_uart_fifo_ctl;

    logic clk = 1'b0;
    logic reset_n;
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    uart_fifo_ctl_if #(.DATA_WIDTH(8), .DEPTH(16)) fif ();

    uart_fifo_ctl #(
        .DATA_WIDTH    (8),
        .DEPTH         (16),
        .AFULL_THRESH  (14),
        .AEMPTY_THRESH (2)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (fif)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cyc(input logic w, input logic [7:0] d, input logic r, input logic c);
        fif.wr_en   = w;
        fif.din     = d;
        fif.rd_en   = r;
        fif.err_clr = c;
        @(posedge clk);
        #1;
        fif.wr_en   = 1'b0;
        fif.rd_en   = 1'b0;
        fif.err_clr = 1'b0;
    endtask

    logic [7:0] q[$];

    initial begin
        logic [7:0] d;
        logic [7:0] e;
        int         lvl;

        reset_n     = 1'b0;
        fif.wr_en   = 1'b0;
        fif.din     = '0;
        fif.rd_en   = 1'b0;
        fif.err_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_level", fif.level, 0);
        chk("rst_empty", fif.empty, 1);
        chk("rst_full", fif.full, 0);
        chk("rst_aempty", fif.almost_empty, 1);
        chk("rst_afull", fif.almost_full, 0);
        chk("rst_dout", fif.dout, 0);
        chk("rst_dvalid", fif.dout_valid, 0);
        chk("rst_ovf", fif.overflow, 0);
        chk("rst_unf", fif.underflow, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

`ifdef UART_FIFO_FWFT_EN
        cyc(1'b1, 8'h3C, 1'b0, 1'b0);
        chk("fw_dout1", fif.dout, 8'h3C);
        chk("fw_dv1", fif.dout_valid, 1);
        chk("fw_lvl1", fif.level, 1);
        cyc(1'b1, 8'h3D, 1'b0, 1'b0);
        chk("fw_dout_hold", fif.dout, 8'h3C);
        chk("fw_lvl2", fif.level, 2);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("fw_dout2", fif.dout, 8'h3D);
        chk("fw_dv2", fif.dout_valid, 1);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("fw_empty", fif.empty, 1);
        chk("fw_dv_off", fif.dout_valid, 0);
        chk("fw_unf_clear", fif.underflow, 0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("fw_unf", fif.underflow, 1);
        chk("fw_lvl0", fif.level, 0);
`else
        // Mid-stream asynchronous reset with level 5 and a live dout.
        for (int i = 0; i < 6; i++) cyc(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("pre_rst_level", fif.level, 5);
        chk("pre_rst_dout", fif.dout, 8'h10);
        chk("pre_rst_dv", fif.dout_valid, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_level", fif.level, 0);
        chk("arst_empty", fif.empty, 1);
        chk("arst_dout", fif.dout, 0);
        chk("arst_dv", fif.dout_valid, 0);
        chk("arst_aempty", fif.almost_empty, 1);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_level", fif.level, 0);
        chk("post_rst_empty", fif.empty, 1);

        // Fill with thresholds tracked at every level.
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 8'(i), 1'b0, 1'b0);
            lvl = i + 1;
            chk("fill_level", fif.level, 32'(lvl));
            chk("fill_aempty", fif.almost_empty, (lvl <= 2) ? 1 : 0);
            chk("fill_afull", fif.almost_full, (lvl >= 14) ? 1 : 0);
            chk("fill_full", fif.full, (lvl == 16) ? 1 : 0);
        end

        // Full: pop wins, push of 0xAA is rejected and flagged.
        cyc(1'b1, 8'hAA, 1'b1, 1'b0);
        chk("full_both_level", fif.level, 15);
        chk("full_both_ovf", fif.overflow, 1);
        chk("full_both_dout", fif.dout, 8'h00);
        chk("full_both_dv", fif.dout_valid, 1);
        chk("full_both_unf", fif.underflow, 0);

        for (int i = 1; i < 16; i++) begin
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
            lvl = 15 - i;
            chk("drain_dout", fif.dout, 32'(i));
            chk("drain_dv", fif.dout_valid, 1);
            chk("drain_level", fif.level, 32'(lvl));
            chk("drain_afull", fif.almost_full, (lvl >= 14) ? 1 : 0);
            chk("drain_aempty", fif.almost_empty, (lvl <= 2) ? 1 : 0);
        end
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        chk("idle_dv", fif.dout_valid, 0);
        chk("idle_dout_hold", fif.dout, 8'h0F);
        chk("drained_empty", fif.empty, 1);

        // Empty: push wins, pop is rejected and flagged.
        cyc(1'b1, 8'h55, 1'b1, 1'b0);
        chk("empty_both_level", fif.level, 1);
        chk("empty_both_unf", fif.underflow, 1);
        chk("empty_both_dout", fif.dout, 8'h0F);
        chk("empty_both_dv", fif.dout_valid, 0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("pop55_dout", fif.dout, 8'h55);
        chk("pop55_empty", fif.empty, 1);

        // err_clr with a simultaneous new underflow: underflow stays, overflow clears.
        cyc(1'b0, 8'h00, 1'b1, 1'b1);
        chk("setwins_unf", fif.underflow, 1);
        chk("setwins_ovf", fif.overflow, 0);
        chk("setwins_dv", fif.dout_valid, 0);
        chk("setwins_dout", fif.dout, 8'h55);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        chk("clr_unf", fif.underflow, 0);

        // Steady push/pop at level 8 across pointer wrap.
        for (int i = 0; i < 8; i++) begin
            d = 8'(8'h80 + i);
            cyc(1'b1, d, 1'b0, 1'b0);
            q.push_back(d);
        end
        chk("wrap_start_level", fif.level, 8);
        for (int i = 0; i < 40; i++) begin
            d = 8'(8'hC0 + i);
            cyc(1'b1, d, 1'b1, 1'b0);
            e = q.pop_front();
            q.push_back(d);
            chk("wrap_dout", fif.dout, 32'(e));
            chk("wrap_level", fif.level, 8);
            chk("wrap_dv", fif.dout_valid, 1);
        end
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
            e = q.pop_front();
            chk("wrap_drain_dout", fif.dout, 32'(e));
        end
        chk("wrap_end_empty", fif.empty, 1);
        chk("wrap_end_ovf", fif.overflow, 0);
        chk("wrap_end_unf", fif.underflow, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uart_fifo_ctl.md
Name: uart_fifo_ctl

Overview:
- Parametrised successor to the simple UART byte FIFO.
- Synchronous single-clock FIFO with:
  - correct count on simultaneous push/pop
  - fill-level output
  - programmable almost-full and almost-empty thresholds
  - sticky overflow and underflow error flags with clear
- Sits between the UART RX/TX engines and the host register interface. One instance per direction.

Parameters:
- DATA_WIDTH, 8, width of each stored word in bits (>=1).
- DEPTH, 16, number of entries. Must be a power of two, >=2. Elaboration fails otherwise.
- AFULL_THRESH, DEPTH-2, almost_full asserts when level >= this value (1..DEPTH).
- AEMPTY_THRESH, 2, almost_empty asserts when level <= this value (0..DEPTH-1).

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- wr_en  input  1  push request
- din  input  DATA_WIDTH  push data
- rd_en  input  1  pop request
- dout  output  DATA_WIDTH  pop data
- dout_valid  output  1  dout holds newly popped word (non-FWFT); equals !empty (FWFT)
- full  output  1  level == DEPTH
- empty  output  1  level == 0
- almost_full  output  1  level >= AFULL_THRESH
- almost_empty  output  1  level <= AEMPTY_THRESH
- level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- overflow  output  1  sticky: push attempted while full
- underflow  output  1  sticky: pop attempted while empty
- err_clr  input  1  synchronous clear of overflow/underflow

Behaviour:
- Reset (reset_n low, asynchronous):
  - pointers = 0, level = 0, dout = 0, dout_valid = 0, overflow = 0, underflow = 0.
  - Hence empty = 1, full = 0, almost_empty = 1, almost_full = 0 (when AFULL_THRESH > 0).
  - Memory contents are not reset.
  - Reset mid-operation discards all contents immediately.
- Acceptance is evaluated on pre-edge state:
  - push_ok = wr_en & !full
  - pop_ok = rd_en & !empty
- Level update on each edge:
  - push_ok & pop_ok: level unchanged
  - push_ok only: level + 1
  - pop_ok only: level - 1
- Simultaneous push and pop, by pre-edge state:
  - when full: pop accepted, push rejected; overflow sets.
  - when empty: push accepted, pop rejected; underflow sets.
  - otherwise: both accepted.
- Pointers: $clog2(DEPTH) bits each, natural binary wrap from DEPTH-1 to 0. Write at wr_ptr, read at rd_ptr.
- Status outputs:
  - full, empty, almost_full, almost_empty are combinational decodes of the registered level.
  - Zero lag: valid the cycle after the edge that changed level.
- Error flags:
  - overflow sets on wr_en & full; underflow sets on rd_en & empty.
  - Both hold until err_clr.
  - err_clr and a new error in the same cycle: the flag stays set (set wins).
- Read timing, non-FWFT (default):
  - pop_ok registers mem[rd_ptr] into dout. Data is visible on the next cycle with dout_valid = 1 for one cycle.
  - dout holds its value when no pop occurs.
- Rejected operations do not change memory, pointers, dout or level.

Optional Feature:
- Macro: UART_FIFO_FWFT_EN.
- Defined (first-word-fall-through):
  - dout always presents mem[rd_ptr]; dout_valid = !empty.
  - rd_en acts as an acknowledge that advances rd_ptr.
  - A word written into an empty FIFO appears on dout the cycle after the write.
- Undefined: the registered-read behaviour above; dout_valid is a one-cycle pulse.

Decomposition:
- Package uart_fifo_pkg holds:
  - function addr_w(depth) returning $clog2(depth)
  - default constants UART_FIFO_DEPTH_DEF = 16 and UART_DATA_W = 8.
- Sub-module uart_fifo_ram: simple dual-port register array.
  - Interface: we, waddr, wdata, raddr, rdata (combinational read).
  - The controller holds pointers, level, flags and the dout register.

Test Plan (DATA_WIDTH=8, DEPTH=16, AFULL_THRESH=14, AEMPTY_THRESH=2, non-FWFT unless stated):
- Reset: hold reset_n=0 mid-stream with level=5 -> all outputs return to reset values asynchronously; after release, level=0 and empty=1.
- Fill/drain ordering: push 0x00..0x0F -> full=1 and level=16. Then 16 pops -> dout 0x00..0x0F in order, each with a one-cycle dout_valid, ending empty=1.
- Thresholds: push 2 -> almost_empty=1. Push 3rd -> almost_empty=0. At level 14 -> almost_full=1; at level 13 -> almost_full=0.
- Simultaneous at boundaries:
  - full, push 0xAA + pop -> level stays 15 after the edge, overflow=1, 0xAA not stored.
  - empty, push 0x55 + pop -> level=1, underflow=1, dout unchanged.
- Wrap-around: 40 cycles of simultaneous push/pop at level 8 -> level stays 8 and the data sequence is preserved across pointer wrap. Then err_clr -> overflow=0, underflow=0.
- FWFT build: push 0x3C into empty -> next cycle dout=0x3C, dout_valid=1. rd_en -> empty=1, dout_valid=0.
